// File: rtl/bus_pkg.sv
// Shared bus definitions: arbiter state encoding, wait-counter width and default slave timeout.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam int unsigned TIMEOUT_DEFAULT = 255;
  localparam int unsigned CNT_W           = 16;

endpackage

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter onto one slave bus; request reaches the slave 1 cycle after mN_valid.
// Owner's ready/rdata follow the slave combinationally; a stalled slave is aborted after TIMEOUT cycles.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned  TIMEOUT  = TIMEOUT_DEFAULT,
  parameter logic [31:0]  ERR_DATA = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        timeout
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;   // 1: m1 was granted last
  logic             own0, own1, own_valid, tmo_hit, done;

  assign own0      = (state_q == OWN0);
  assign own1      = (state_q == OWN1);
  assign own_valid = (own0 && m0_valid) || (own1 && m1_valid);
  // Slave completion in the last allowed cycle takes priority over the abort.
  assign tmo_hit   = own_valid && !s_ready && (cnt_q == CNT_LAST);
  assign done      = own_valid && (s_ready || tmo_hit);

  always_comb begin
    s_valid  = own_valid && !tmo_hit;
    s_addr   = '0;
    s_wdata  = '0;
    s_wstrb  = '0;
    grant    = {own1, own0};
    timeout  = tmo_hit;
    m0_ready = own0 && done;
    m1_ready = own1 && done;
    m0_rdata = '0;
    m1_rdata = '0;
    if (own0) begin
      s_addr   = m0_addr;
      s_wdata  = m0_wdata;
      s_wstrb  = m0_wstrb;
      m0_rdata = tmo_hit ? ERR_DATA : s_rdata;
    end else if (own1) begin
      s_addr   = m1_addr;
      s_wdata  = m1_wdata;
      s_wstrb  = m1_wstrb;
      m1_rdata = tmo_hit ? ERR_DATA : s_rdata;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (m0_valid && m1_valid) state_d = last_q ? OWN0 : OWN1;
        else if (m0_valid)        state_d = OWN0;
        else if (m1_valid)        state_d = OWN1;
      end
      OWN0, OWN1: begin
        if (!own_valid) begin
          state_d = IDLE;
        end else if (done) begin
          state_d = IDLE;
          last_d  = own1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: slave cycles allowed per transaction before abort (range 2..65535).
REQ-002 Parameter ERR_DATA, default 32'hFFFF_FFFF: read data returned on timeout.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 m0_valid, m1_valid  in  1  request from master 0 (CPU) / master 1 (DMA); held until matching ready.
REQ-006 m0_ready, m1_ready  out  1  transaction complete for master 0 / 1.
REQ-007 m0_addr, m1_addr  in  32  byte address.
REQ-008 m0_wdata, m1_wdata  in  32  write data.
REQ-009 m0_wstrb, m1_wstrb  in  4  byte strobes; 0 = read.
REQ-010 m0_rdata, m1_rdata  out  32  read data.
REQ-011 s_valid  out  1  request to the shared slave bus.
REQ-012 s_ready  in  1  slave completion.
REQ-013 s_addr  out  32; s_wdata  out  32; s_wstrb  out  4  forwarded request.
REQ-014 s_rdata  in  32  slave read data.
REQ-015 grant  out  2  one-hot current owner (bit0 = m0, bit1 = m1); 0 when idle.
REQ-016 timeout  out  1  one-cycle pulse when a transaction is aborted.

Function
REQ-017 The FSM SHALL have states IDLE, OWN0, OWN1.
REQ-018 IDLE: s_valid=0, grant=0, both mN_ready=0; s_addr/s_wdata/s_wstrb SHALL be 0.
REQ-019 IDLE with exactly one mN_valid SHALL move to OWNN next cycle.
REQ-020 IDLE with both valid SHALL grant the master not granted last (round-robin); after reset, m0 wins first.
REQ-021 In OWNN: s_valid=mN_valid, s_addr/s_wdata/s_wstrb = master N's inputs, grant bit N=1, combinationally.
REQ-022 In OWNN, mN_ready SHALL equal s_ready and mN_rdata SHALL equal s_rdata; the non-owner's ready SHALL be 0.
REQ-023 s_ready in OWNN SHALL return the FSM to IDLE next cycle and record N as last-granted.
REQ-024 Minimum latency from mN_valid rise to s_valid = 1 cycle; back-to-back transactions SHALL have one idle cycle between.
REQ-025 mN_valid dropping while OWNN (protocol violation) SHALL return to IDLE next cycle, no ready issued.
REQ-026 A 16-bit wait counter SHALL clear on entry to OWNN and increment each cycle without s_ready.
REQ-027 Counter reaching TIMEOUT-1 without s_ready SHALL, in that cycle, assert mN_ready, drive mN_rdata=ERR_DATA, pulse timeout, and drop s_valid to 0.
REQ-028 s_ready in the same cycle as the timeout condition SHALL win: normal completion, no timeout pulse.
REQ-029 mN_rdata SHALL be 0 whenever master N is not owner.

Reset
REQ-030 rst SHALL force IDLE, counter=0, last-granted=m1 (so m0 wins first tie), timeout=0, all outputs to IDLE values.
REQ-031 rst asserted mid-transaction SHALL abandon it: s_valid=0 the cycle after rst samples high; no ready issued.

Structure
REQ-032 State encodings (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2) and default TIMEOUT SHALL live in the shared bus_pkg.
REQ-033 The block SHALL be a single module with no sub-modules; output muxing combinational, FSM/counter/last-granted registered.

Verification
REQ-034 m0 read addr 0x1000, slave ready after 2 cycles with 0xDEADBEEF -> s_valid 1 cycle after m0_valid, m0_rdata=0xDEADBEEF with m0_ready, grant=01.
REQ-035 m0 and m1 valid same cycle from reset, 3 rounds -> grant order 01,10,01,10,01,10.
REQ-036 m1 write 0x2004 data 0x12345678 wstrb 4'b0011 -> s_wstrb=0011, s_wdata matches, m0_ready stays 0.
REQ-037 TIMEOUT=8, slave never ready -> m0_ready and timeout pulse exactly 8 cycles after grant, m0_rdata=0xFFFFFFFF, then IDLE.
REQ-038 rst pulsed during OWN1 wait -> s_valid=0, grant=00 next cycle; following tie grants m0.
